// File: rtl/weight_update_engine_if.sv
// Bus bundle for weight_update_engine: training inputs, weight preload/read port,
// delta/status outputs. master = driver side, slave = engine side.
interface weight_update_engine_if #(
   parameter int N_HID = 5,
   parameter int N_OUT = 3,
   parameter int W     = 10
);
   logic                 start;
   logic [N_OUT*W-1:0]   out_actual;
   logic [N_OUT*W-1:0]   out_cal;
   logic [N_HID*W-1:0]   hid_cal;
   logic                 wr_en;
   logic [7:0]           wr_addr;
   logic [W-1:0]         wr_data;
   logic [7:0]           rd_addr;
   logic [W-1:0]         rd_data;
   logic [N_OUT*W-1:0]   delta;
   logic                 busy;
   logic                 done;

   modport master (
      output start, out_actual, out_cal, hid_cal, wr_en, wr_addr, wr_data, rd_addr,
      input  rd_data, delta, busy, done
   );

   modport slave (
      input  start, out_actual, out_cal, hid_cal, wr_en, wr_addr, wr_data, rd_addr,
      output rd_data, delta, busy, done
   );
endinterface

// File: rtl/weight_update_engine.sv
// Output-layer backprop engine: per-neuron sigmoid-derivative deltas, then w += delta*hid.
// Optional macro WEIGHT_SAT_EN saturates weight updates instead of wrapping.
module weight_update_engine #(
   parameter int N_HID    = 5,
   parameter int N_OUT    = 3,
   parameter int W        = 10,
   parameter int LR_SHIFT = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   weight_update_engine_if.slave   bus_io
);

   localparam int NW = N_OUT * N_HID;
   localparam int AW = (NW > 1) ? $clog2(NW) : 1;
   localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;
   localparam int PW = 2*W + 3;
   localparam int QW = 2*W + 2;
   localparam logic signed [PW-1:0] DMAX = PW'(2**(W-1) - 1);
   localparam logic signed [PW-1:0] DMIN = PW'(-(2**(W-1)));
`ifdef WEIGHT_SAT_EN
   localparam logic signed [QW-1:0] WMAX = QW'(2**(W-1) - 1);
   localparam logic signed [QW-1:0] WMIN = QW'(-(2**(W-1)));
`endif

   typedef enum logic [1:0] {S_IDLE, S_DELTA, S_UPDATE, S_FIN} state_e;

   state_e                state_q, state_d;
   logic [N_OUT*W-1:0]    act_q, cal_q;
   logic [N_HID*W-1:0]    hid_q;
   logic signed [W-1:0]   delta_q [N_OUT];
   logic [W-1:0]          w_q [NW];
   logic [W-1:0]          rd_data_q;
   logic [KW-1:0]         k_q;
   logic [JW-1:0]         j_q;
   logic [AW-1:0]         i_q;
   logic                  busy, done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE:   if (bus_io.start) state_d = S_DELTA;
         S_DELTA: begin
            busy = 1'b1;
            if (k_q == KW'(N_OUT-1)) state_d = S_UPDATE;
         end
         S_UPDATE: begin
            busy = 1'b1;
            if (i_q == AW'(NW-1)) state_d = S_FIN;
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // Delta for neuron k_q from the captured sample
   logic [W-1:0]          act_k, cal_k;
   logic [W:0]            sp_comp, sp;
   logic [2*W:0]          sp_full;
   logic signed [W:0]     err;
   logic signed [PW-1:0]  dprod, dshr;
   logic signed [W-1:0]   delta_new;

   always_comb begin
      act_k     = act_q[k_q*W +: W];
      cal_k     = cal_q[k_q*W +: W];
      sp_comp   = {1'b1, {W{1'b0}}} - {1'b0, cal_k};
      sp_full   = {{W{1'b0}}, sp_comp} * {{(W+1){1'b0}}, cal_k};
      sp        = (W+1)'(sp_full >> W);
      err       = $signed({1'b0, act_k}) - $signed({1'b0, cal_k});
      dprod     = PW'(err) * PW'($signed({1'b0, sp}));
      dshr      = dprod >>> W;
      delta_new = W'(dshr);
      if (dshr > DMAX)      delta_new = {1'b0, {(W-1){1'b1}}};
      else if (dshr < DMIN) delta_new = {1'b1, {(W-1){1'b0}}};
   end

   // Weight update for entry i_q = k_q*N_HID + j_q
   logic signed [W-1:0]   delta_k;
   logic [W-1:0]          hid_j;
   logic signed [QW-1:0]  uprod, ushr, usum;
   logic [W-1:0]          w_new;

   always_comb begin
      delta_k = delta_q[k_q];
      hid_j   = hid_q[j_q*W +: W];
      uprod   = QW'(delta_k) * QW'($signed({1'b0, hid_j}));
      ushr    = uprod >>> (W + LR_SHIFT);
      usum    = QW'($signed(w_q[i_q])) + ushr;
      w_new   = W'(usum);
`ifdef WEIGHT_SAT_EN
      if (usum > WMAX)      w_new = {1'b0, {(W-1){1'b1}}};
      else if (usum < WMIN) w_new = {1'b1, {(W-1){1'b0}}};
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         act_q     <= '0;
         cal_q     <= '0;
         hid_q     <= '0;
         k_q       <= '0;
         j_q       <= '0;
         i_q       <= '0;
         rd_data_q <= '0;
         for (int unsigned n = 0; n < N_OUT; n++) delta_q[n] <= '0;
         for (int unsigned n = 0; n < NW; n++)    w_q[n]     <= '0;
      end else begin
         rd_data_q <= (bus_io.rd_addr < 8'(NW)) ? w_q[bus_io.rd_addr[AW-1:0]] : '0;
         case (state_q)
            S_IDLE: begin
               if (bus_io.wr_en && (bus_io.wr_addr < 8'(NW)))
                  w_q[bus_io.wr_addr[AW-1:0]] <= bus_io.wr_data;
               if (bus_io.start) begin
                  act_q <= bus_io.out_actual;
                  cal_q <= bus_io.out_cal;
                  hid_q <= bus_io.hid_cal;
                  k_q   <= '0;
                  j_q   <= '0;
                  i_q   <= '0;
               end
            end
            S_DELTA: begin
               delta_q[k_q] <= delta_new;
               k_q          <= (k_q == KW'(N_OUT-1)) ? '0 : k_q + KW'(1);
            end
            S_UPDATE: begin
               w_q[i_q] <= w_new;
               i_q      <= i_q + AW'(1);
               // k/j walk the row-major index without a divider
               if (j_q == JW'(N_HID-1)) begin
                  j_q <= '0;
                  k_q <= k_q + KW'(1);
               end else begin
                  j_q <= j_q + JW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   logic [N_OUT*W-1:0] delta_pk;

   always_comb begin
      delta_pk = '0;
      for (int unsigned n = 0; n < N_OUT; n++) delta_pk[n*W +: W] = delta_q[n];
   end

   assign bus_io.delta   = delta_pk;
   assign bus_io.rd_data = rd_data_q;
   assign bus_io.busy    = busy;
   assign bus_io.done    = done;

endmodule

// File: tb/tb_weight_update_engine.sv
// Bench for weight_update_engine: arithmetic reference model plus directed scenarios
// with hand-computed literals; honours WEIGHT_SAT_EN like the design.
module tb_weight_update_engine;
   localparam int N_HID = 5;
   localparam int N_OUT = 3;
   localparam int W     = 10;
   localparam int LR    = 0;
   localparam int NW    = N_OUT * N_HID;
   localparam int LAT   = N_OUT + NW + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   weight_update_engine_if #(.N_HID(N_HID), .N_OUT(N_OUT), .W(W)) bus ();

   weight_update_engine #(.N_HID(N_HID), .N_OUT(N_OUT), .W(W), .LR_SHIFT(LR)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int pass_no  = 0;
   int exp_w     [NW]    = '{default: 0};
   int exp_delta [N_OUT] = '{default: 0};
   int tw [NW];
   int td [N_OUT];
   int in_act [N_OUT];
   int in_cal [N_OUT];
   int in_hid [N_HID];

   function automatic int sxt(input int v);
      return ((v & ((1 << W) - 1)) ^ (1 << (W-1))) - (1 << (W-1));
   endfunction

   function automatic int f_delta(input int a, input int c);
      int err, sp, d;
      err = a - c;
      sp  = (c * ((1 << W) - c)) >>> W;
      d   = (err * sp) >>> W;
      if (d > (1 << (W-1)) - 1) d = (1 << (W-1)) - 1;
      if (d < -(1 << (W-1)))    d = -(1 << (W-1));
      return d;
   endfunction

   function automatic int f_upd(input int w, input int d, input int h);
      int s;
      s = w + ((d * h) >>> (W + LR));
`ifdef WEIGHT_SAT_EN
      if (s > (1 << (W-1)) - 1) s = (1 << (W-1)) - 1;
      if (s < -(1 << (W-1)))    s = -(1 << (W-1));
      return s;
`else
      return sxt(s);
`endif
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Reference model: a whole pass is resolved at the accepted Start edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_no <= 0;
         for (int i = 0; i < NW; i++)    exp_w[i]     <= 0;
         for (int k = 0; k < N_OUT; k++) exp_delta[k] <= 0;
      end else begin
         tw = exp_w;
         td = exp_delta;
         if (pass_no == 0 && bus.wr_en && int'(bus.wr_addr) < NW)
            tw[int'(bus.wr_addr)] = sxt(int'(bus.wr_data));
         if (pass_no == 0 && bus.start) begin
            for (int k = 0; k < N_OUT; k++)
               td[k] = f_delta(int'(bus.out_actual[k*W +: W]), int'(bus.out_cal[k*W +: W]));
            for (int i = 0; i < NW; i++)
               tw[i] = f_upd(tw[i], td[i / N_HID], int'(bus.hid_cal[(i % N_HID)*W +: W]));
            pass_no <= 1;
         end else if (pass_no > 0) begin
            pass_no <= (pass_no == LAT) ? 0 : pass_no + 1;
         end
         exp_w     <= tw;
         exp_delta <= td;
      end
   end

   always @(negedge clk) begin
      check("busy", int'(bus.busy), int'(pass_no >= 1 && pass_no <= LAT - 1));
      check("done", int'(bus.done), int'(pass_no == LAT));
      if (pass_no == 0 || pass_no > N_OUT)
         for (int k = 0; k < N_OUT; k++)
            check($sformatf("delta%0d", k), sxt(int'(bus.delta[k*W +: W])), exp_delta[k]);
   end

   task automatic pack();
      for (int k = 0; k < N_OUT; k++) begin
         bus.out_actual[k*W +: W] = W'(in_act[k]);
         bus.out_cal[k*W +: W]    = W'(in_cal[k]);
      end
      for (int j = 0; j < N_HID; j++) bus.hid_cal[j*W +: W] = W'(in_hid[j]);
   endtask

   task automatic wr(input int addr, input int data);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 8'(addr);
      bus.wr_data = W'(data);
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic rd_check(input string name, input int addr, input int exp);
      bus.rd_addr = 8'(addr);
      @(negedge clk);
      check(name, sxt(int'(bus.rd_data)), exp);
   endtask

   task automatic read_all_model();
      for (int i = 0; i < NW; i++) rd_check($sformatf("w%0d", i), i, exp_w[i]);
   endtask

   task automatic run_pass(input bit extra, output int ndone);
      int cyc;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc   = 1;
      ndone = 0;
      while (!bus.done && cyc < 100) begin
         bus.start   = extra && (cyc == 5);
         bus.wr_en   = extra && (cyc == 5);
         bus.wr_addr = 8'd0;
         bus.wr_data = W'(7);
         @(negedge clk);
         cyc++;
      end
      bus.wr_en = 1'b0;
      check("latency", cyc, LAT);
      if (bus.done) ndone = 1;
      bus.start = extra;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (extra ? 25 : 1) begin
         if (bus.done) ndone++;
         @(negedge clk);
      end
   endtask

   task automatic set_default_inputs();
      for (int k = 0; k < N_OUT; k++) begin in_act[k] = 512; in_cal[k] = 512; end
      for (int j = 0; j < N_HID; j++) in_hid[j] = 512;
      in_act[0] = 768;
      pack();
   endtask

   initial begin
      int nd;
      int row_inc [N_OUT];
      row_inc[0] = 32; row_inc[1] = 16; row_inc[2] = -16;
      bus.start = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.rd_addr = '0; bus.out_actual = '0; bus.out_cal = '0; bus.hid_cal = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_delta", int'(bus.delta), 0);

      // First Start right on the first edge after reset release
      set_default_inputs();
      rst_n = 1'b1;
      run_pass(1'b0, nd);
      check("first_delta0", sxt(int'(bus.delta[W-1:0])), 64);
      rd_check("first_w0", 0, 32);

      // w0=100, err=+256 -> delta 64, w0 132
      wr(0, 100);
      run_pass(1'b0, nd);
      check("a_delta0", sxt(int'(bus.delta[W-1:0])), 64);
      rd_check("a_w0", 0, 132);
      read_all_model();

      // w0=0, err=-256 -> delta -64, w0 -32
      wr(0, 0);
      in_act[0] = 256; pack();
      run_pass(1'b0, nd);
      check("b_delta0", sxt(int'(bus.delta[W-1:0])), -64);
      rd_check("b_w0", 0, -32);
      check("b_w0_raw", int'(bus.rd_data), 'h3E0);

      // Overflow case
      wr(0, 500);
      in_act[0] = 1023; in_hid[0] = 1023; pack();
      run_pass(1'b0, nd);
      check("c_delta0", sxt(int'(bus.delta[W-1:0])), 127);
`ifdef WEIGHT_SAT_EN
      rd_check("c_w0", 0, 511);
`else
      rd_check("c_w0", 0, -398);
`endif
      read_all_model();

      // Start during busy/done and a write while busy are both dropped
      wr(0, 100);
      set_default_inputs();
      run_pass(1'b1, nd);
      check("d_ndone", nd, 1);
      rd_check("d_w0", 0, 132);

      // Distinct per-neuron deltas
      for (int i = 0; i < NW; i++) wr(i, 0);
      in_act[0] = 768; in_act[1] = 640; in_act[2] = 384; pack();
      run_pass(1'b0, nd);
      check("e_delta0", sxt(int'(bus.delta[0*W +: W])), 64);
      check("e_delta1", sxt(int'(bus.delta[1*W +: W])), 32);
      check("e_delta2", sxt(int'(bus.delta[2*W +: W])), -32);
      for (int i = 0; i < NW; i++) rd_check($sformatf("e_w%0d", i), i, row_inc[i / N_HID]);

      // Out-of-range and same-cycle read/write
      wr(16, 55);
      wr(255, 55);
      rd_check("oor_w0", 0, 32);
      rd_check("oor_rd15", 15, 0);
      rd_check("oor_rd200", 200, 0);
      bus.rd_addr = 8'd2;
      wr(2, 77);
      check("rw_old", sxt(int'(bus.rd_data)), 32);
      @(negedge clk);
      check("rw_new", sxt(int'(bus.rd_data)), 77);
      read_all_model();

      // Reset mid-UPDATE
      set_default_inputs();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("r_busy", int'(bus.busy), 0);
      check("r_done", int'(bus.done), 0);
      check("r_delta", int'(bus.delta), 0);
      check("r_rd", int'(bus.rd_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NW; i++) rd_check($sformatf("r_w%0d", i), i, 0);
      run_pass(1'b0, nd);
      rd_check("r_w0_after", 0, 32);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end
endmodule

// File: doc/weight_update_engine.md
WEIGHT_UPDATE_ENGINE -- requirements
Module: weight_update_engine

Interface
REQ-001 Parameter N_HID, default 5, hidden-neuron count (range 1..16).
REQ-002 Parameter N_OUT, default 3, output-neuron count (range 1..8).
REQ-003 Parameter W, default 10, data width; activations are unsigned Q0.W, weights and deltas are signed two's complement.
REQ-004 Parameter LR_SHIFT, default 0, learning-rate right shift (range 0..7).
REQ-005 Clock  in  1  single clock; all state updates on the rising edge.
REQ-006 Rst  in  1  asynchronous, active-low reset.
REQ-007 Start  in  1  request one training pass; sampled only in IDLE.
REQ-008 OutActual  in  N_OUT*W  target outputs; neuron k is at bits [k*W +: W].
REQ-009 OutCal  in  N_OUT*W  calculated outputs of the output layer, same packing as OutActual.
REQ-010 HidCal  in  N_HID*W  calculated hidden-layer outputs, same packing.
REQ-011 WrEn, WrAddr[7:0], WrData[W-1:0]  in  weight preload port; address = k*N_HID + j.
REQ-012 RdAddr[7:0]  in  weight read address.
REQ-013 RdData  out  W  weight at RdAddr, registered.
REQ-014 Delta  out  N_OUT*W  per-neuron signed deltas, registered.
REQ-015 Busy  out  1  high while a training pass is in progress.
REQ-016 Done  out  1  one-cycle pulse at the end of each pass.

Function
REQ-017 The FSM SHALL have four states: IDLE, DELTA, UPDATE, FIN.
- IDLE to DELTA when Start=1.
- DELTA to UPDATE after N_OUT cycles.
- UPDATE to FIN after N_OUT*N_HID cycles.
- FIN to IDLE unconditionally.
REQ-018 On the Start edge the block SHALL capture OutActual, OutCal and HidCal; later input changes SHALL NOT affect the pass in progress.
REQ-019 DELTA cycle k SHALL compute the following and register the result into Delta[k]:
- err = actual[k] - cal[k], signed W+1 bits.
- sp = (cal[k]*(2^W - cal[k])) >> W.
- d = (err*sp) >> W, arithmetic shift, saturated to signed W bits.
REQ-020 UPDATE cycle i (k = i / N_HID, j = i % N_HID) SHALL compute w[i] += (Delta[k]*hid[j]) >> (W+LR_SHIFT), arithmetic shift; overflow handling is per REQ-030.
REQ-021 Each neuron k SHALL use its own Delta[k]; one delta SHALL NOT be shared across neurons.
REQ-022 Busy SHALL be 1 in DELTA and UPDATE, and 0 otherwise.
REQ-023 Done SHALL be 1 only in FIN.
REQ-024 Latency: Done SHALL assert exactly N_OUT + N_OUT*N_HID + 1 cycles after the Start edge (19 at defaults).
REQ-025 Start while Busy or Done is high SHALL be ignored; there SHALL be no queueing.
REQ-026 WrEn SHALL write WrData to w[WrAddr] only in IDLE.
- WrEn while Busy SHALL be dropped.
- WrAddr >= N_OUT*N_HID SHALL be ignored.
REQ-027 RdData SHALL return w[RdAddr] one cycle after RdAddr is presented.
- An out-of-range address SHALL read 0.
- Reading an address written in the same cycle SHALL return the old value.

Reset
REQ-028 Rst=0 SHALL immediately (asynchronously) set the following, including mid-pass; no partial pass SHALL resume after reset:
- state = IDLE
- Busy = 0, Done = 0
- Delta = 0, RdData = 0
- all weights = 0
- captured inputs = 0
REQ-029 After Rst deasserts, the first Start SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro WEIGHT_SAT_EN:
- Defined: weight-update overflow SHALL saturate to +(2^(W-1)-1) or -2^(W-1).
- Undefined: the weight result SHALL wrap modulo 2^W.
- The delta saturation of REQ-019 applies in both builds.

Verification
(All scenarios use default parameters and LR_SHIFT=0.)
REQ-031 Preload w[0]=100; actual0=768, cal0=512, hid0=512; Start -> Delta[0]=64, w[0]=132, Done on cycle 19.
REQ-032 Preload w[0]=0; actual0=256, cal0=512, hid0=512 -> Delta[0]=-64, w[0]=-32 (0x3E0).
REQ-033 Preload w[0]=500; actual0=1023, cal0=512, hid0=1023 -> Delta[0]=127, and:
- with WEIGHT_SAT_EN: w[0]=511;
- without it: w[0]=-398.
REQ-034 Pulse Start at cycle 5 of a pass, and WrEn to addr 0 while Busy -> exactly one Done, w[0] unaffected by the write.
REQ-035 Assert Rst low at UPDATE cycle 7 -> Busy=0, Done=0, Delta=0, all RdData reads 0; next Start completes normally in 19 cycles.
REQ-036 Set distinct deltas per neuron (cal=512; actual=768, 640, 384) with all hid=512 -> row increments +32, +16, -16 respectively, confirming per-neuron delta use.
